// File: rtl/clap_pkg.sv
// -----------------------------------------------------------------------------
// clap_pkg
// Shared definitions for the clap-clap light: FSM state encoding and the
// default ADC zero level / peak threshold used by the sequencer and by the
// capture-side bench.
// -----------------------------------------------------------------------------
package clap_pkg;

    // ADC defaults (offset-binary counts)
    localparam int DEF_MIDSCALE  = 2048;
    localparam int DEF_THRESHOLD = 1024;

    // FSM state encoding, visible on the debug 'state' port
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD1 = 2'd1;
    localparam logic [1:0] ST_WAIT2 = 2'd2;
    localparam logic [1:0] ST_HOLD2 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        HOLD1 = ST_HOLD1,
        WAIT2 = ST_WAIT2,
        HOLD2 = ST_HOLD2
    } clap_state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clap_peak_detect.sv
// -----------------------------------------------------------------------------
// clap_peak_detect
// One registered stage: magnitude of the sample about mid-scale, compared
// against the peak threshold (inclusive).
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sample       in   DATA_W  unsigned offset-binary sample
//   sample_valid in   1       sample qualifies for evaluation
//   peak         out  1       |sample - MIDSCALE| >= THRESHOLD (registered)
//   peak_valid   out  1       'peak' carries an evaluated sample
// -----------------------------------------------------------------------------
module clap_peak_detect
    import clap_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MIDSCALE  = DEF_MIDSCALE,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic              peak,
    output logic              peak_valid
);

    localparam logic signed [DATA_W:0] MID_S = (DATA_W+1)'(MIDSCALE);
    localparam logic        [DATA_W:0] THR_U = (DATA_W+1)'(THRESHOLD);

    // The difference needs one extra bit so both signs fit; the magnitude of
    // that difference can never reach 2^DATA_W, so no saturation is needed.
    function automatic logic [DATA_W:0] abs_mag(input logic signed [DATA_W:0] d);
        return d[DATA_W] ? $unsigned(-d) : $unsigned(d);
    endfunction

    logic signed [DATA_W:0] diff_p0;
    logic        [DATA_W:0] mag_p0;
    logic                   hit_p0;

    assign diff_p0 = $signed({1'b0, sample}) - MID_S;
    assign mag_p0  = abs_mag(diff_p0);
    assign hit_p0  = (mag_p0 >= THR_U);

    // ---- stage p0 -> p1 : registered peak decision ----
    logic peak_p1;
    logic vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            peak_p1 <= hit_p0;
            vld_p1  <= sample_valid;
        end
    end

    assign peak       = peak_p1;
    assign peak_valid = vld_p1;

endmodule

// File: rtl/clap_sequencer.sv
// -----------------------------------------------------------------------------
// clap_sequencer
// Drains the ADC AXI-Stream sample feed, turns every accepted sample into a
// peak / no-peak decision and runs the double-clap FSM. All timing in the FSM
// is counted in evaluated samples, never in clock cycles. A valid double clap
// toggles the lamp.
//
// Ports:
//   s00_axis_aclk     in   clock, rising edge
//   s00_axis_aresetn  in   asynchronous active-low reset
//   s00_axis_tvalid   in   sample valid
//   s00_axis_tdata    in   C_S00_AXIS_TDATA_WIDTH unsigned offset-binary sample
//   s00_axis_tstrb    in   byte strobes, ignored
//   s00_axis_tready   out  registered copy of 'enable'
//   enable            in   detection enable
//   light             out  lamp drive, toggles on each double clap
//   clap_pulse        out  one-cycle strobe per counted clap
//   state             out  FSM state (debug)
//
// Latency: handshake at edge N, peak decision at N+1, FSM/light/pulse at N+2.
// -----------------------------------------------------------------------------
module clap_sequencer
    import clap_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 16,
    parameter int MIDSCALE               = DEF_MIDSCALE,
    parameter int THRESHOLD              = DEF_THRESHOLD,
    parameter int HOLDOFF_SAMPLES        = 200,
    parameter int WINDOW_SAMPLES         = 2000
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    output logic                                  s00_axis_tready,
    input  logic                                  enable,
    output logic                                  light,
    output logic                                  clap_pulse,
    output logic [1:0]                            state
);

    localparam int CNT_MAX = max_of(HOLDOFF_SAMPLES, WINDOW_SAMPLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_SAMPLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_SAMPLES - 1);

    // Strobes carry no meaning for a single-sample stream.
    logic unused_tstrb;
    assign unused_tstrb = ^s00_axis_tstrb;

    logic tready_q;
    logic accept;

    assign accept = s00_axis_tvalid & tready_q;

    // ---- stage p0 : sample capture on handshake ----
    // Any handshake that completes while enable is low is dropped here, and
    // every later stage is qualified with enable too, so nothing that was in
    // flight when detection stopped is ever evaluated.
    logic [C_S00_AXIS_TDATA_WIDTH-1:0] data_p0;
    logic                              vld_p0;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            tready_q <= 1'b0;
            data_p0  <= '0;
            vld_p0   <= 1'b0;
        end else begin
            tready_q <= enable;
            vld_p0   <= accept & enable;
            if (accept) begin
                data_p0 <= s00_axis_tdata;
            end
        end
    end

    // ---- stage p1 : magnitude / peak ----
    logic peak_p1;
    logic vld_p1;

    clap_peak_detect #(
        .DATA_W    (C_S00_AXIS_TDATA_WIDTH),
        .MIDSCALE  (MIDSCALE),
        .THRESHOLD (THRESHOLD)
    ) u_peak (
        .clk          (s00_axis_aclk),
        .rst_n        (s00_axis_aresetn),
        .sample       (data_p0),
        .sample_valid (vld_p0 & enable),
        .peak         (peak_p1),
        .peak_valid   (vld_p1)
    );

    logic eval_p1;
    assign eval_p1 = vld_p1 & enable;

    // ---- stage p2 : clap FSM, sample counter, lamp ----
    clap_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             light_q, light_d;
    logic             pulse_q, pulse_d;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            light_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            light_q <= light_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        light_d = light_q;
        pulse_d = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (eval_p1) begin
            case (state_q)
                IDLE: begin
                    if (peak_p1) begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD1;
                    end
                end
                HOLD1: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = WAIT2;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT2: begin
                    // A peak on the last window sample still counts.
                    if (peak_p1) begin
                        light_d = ~light_q;
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD2;
                    end else if (cnt_q == WIN_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD2: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign s00_axis_tready = tready_q;
    assign light           = light_q;
    assign clap_pulse      = pulse_q;
    assign state           = state_q;

endmodule
